// File: rtl/lcd_line_writer_if.sv
// rtl/lcd_line_writer_if.sv - host buffer/start port and clplcd request/done handshake
interface lcd_line_writer_if;
  logic       start;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       error;
  logic       lcd_init;
  logic       lcd_resetreq;
  logic       lcd_addrreq;
  logic       lcd_datareq;
  logic       lcd_clearreq;
  logic       lcd_homereq;
  logic       lcd_cmdreq;
  logic [7:0] lcd_din;
  logic       lcd_reset_done;
  logic       lcd_addr_done;
  logic       lcd_data_done;

  modport master (
    input  start, wr_en, wr_addr, wr_data,
    input  lcd_reset_done, lcd_addr_done, lcd_data_done,
    output busy, done, error,
    output lcd_init, lcd_resetreq, lcd_addrreq, lcd_datareq,
    output lcd_clearreq, lcd_homereq, lcd_cmdreq, lcd_din
  );

  modport slave (
    output start, wr_en, wr_addr, wr_data,
    output lcd_reset_done, lcd_addr_done, lcd_data_done,
    input  busy, done, error,
    input  lcd_init, lcd_resetreq, lcd_addrreq, lcd_datareq,
    input  lcd_clearreq, lcd_homereq, lcd_cmdreq, lcd_din
  );
endinterface

// File: rtl/lcd_line_writer.sv
// rtl/lcd_line_writer.sv - sequences panel reset, line addresses and 2x16 characters into clplcd
module lcd_line_writer #(
  parameter int         CHARS_PER_LINE = 16,
  parameter logic [6:0] LINE1_ADDR     = 7'h00,
  parameter logic [6:0] LINE2_ADDR     = 7'h40,
  parameter int         TIMEOUT        = 4194304
) (
  input logic              CLK,
  input logic              reset,
  lcd_line_writer_if.master bus
);

  localparam int BUF_DEPTH = 2 * CHARS_PER_LINE;
  localparam int AW        = $clog2(BUF_DEPTH);
  localparam int CW        = $clog2(CHARS_PER_LINE);
  localparam logic [CW-1:0] LAST_CHAR = CW'(CHARS_PER_LINE - 1);
  localparam logic [22:0]   TMO_LAST  = 23'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, REQ, FINISH} state_t;
  typedef enum logic [1:0] {OP_RESET, OP_ADDR, OP_DATA} op_t;

  state_t        state, state_n;
  op_t           op, op_n;
  logic          line, line_n;
  logic [CW-1:0] char_idx, char_n;
  logic [22:0]   tmo_cnt, cnt_n;
  logic          panel_ready, ready_n;
  logic          error_q, err_n;
  logic [7:0]    din_q, din_n;
  logic [7:0]    msg_buf [BUF_DEPTH];
  logic [AW-1:0] rd_idx;
  logic          op_done;

  // Host writes only land while idle so a running update sees a frozen buffer.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) msg_buf[i] <= 8'h20;
    end else if (bus.wr_en && state == IDLE) begin
      msg_buf[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign rd_idx  = line ? AW'(CHARS_PER_LINE) + AW'(char_idx) : AW'(char_idx);
  assign op_done = (op == OP_RESET && bus.lcd_reset_done) ||
                   (op == OP_ADDR  && bus.lcd_addr_done)  ||
                   (op == OP_DATA  && bus.lcd_data_done);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      op          <= OP_RESET;
      line        <= 1'b0;
      char_idx    <= '0;
      tmo_cnt     <= '0;
      panel_ready <= 1'b0;
      error_q     <= 1'b0;
      din_q       <= 8'h00;
    end else begin
      state       <= state_n;
      op          <= op_n;
      line        <= line_n;
      char_idx    <= char_n;
      tmo_cnt     <= cnt_n;
      panel_ready <= ready_n;
      error_q     <= err_n;
      din_q       <= din_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op;
    line_n  = line;
    char_n  = char_idx;
    cnt_n   = tmo_cnt;
    ready_n = panel_ready;
    err_n   = error_q;
    din_n   = din_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = ISSUE;
          err_n   = 1'b0;
          line_n  = 1'b0;
          char_n  = '0;
          op_n    = panel_ready ? OP_ADDR : OP_RESET;
        end
      end
      ISSUE: begin
        cnt_n   = '0;
        state_n = REQ;
        case (op)
          OP_ADDR: din_n = {1'b0, line ? LINE2_ADDR : LINE1_ADDR};
          OP_DATA: din_n = msg_buf[rd_idx];
          default: din_n = 8'h00;
        endcase
      end
      REQ: begin
        if (op_done) begin
          state_n = ISSUE;
          case (op)
            OP_RESET: begin
              ready_n = 1'b1;
              op_n    = OP_ADDR;
            end
            OP_ADDR: begin
              op_n   = OP_DATA;
              char_n = '0;
            end
            default: begin
              if (char_idx != LAST_CHAR) begin
                char_n = char_idx + CW'(1);
              end else if (!line) begin
                line_n = 1'b1;
                op_n   = OP_ADDR;
              end else begin
                state_n = FINISH;
              end
            end
          endcase
        end else if (tmo_cnt == TMO_LAST) begin
          // A silent controller leaves the panel in an unknown state; force a re-reset next time.
          state_n = IDLE;
          err_n   = 1'b1;
          ready_n = 1'b0;
        end else begin
          cnt_n = tmo_cnt + 23'd1;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == FINISH);
  assign bus.error        = error_q;
  assign bus.lcd_init     = (state == ISSUE);
  assign bus.lcd_resetreq = (state == REQ) && (op == OP_RESET);
  assign bus.lcd_addrreq  = (state == REQ) && (op == OP_ADDR);
  assign bus.lcd_datareq  = (state == REQ) && (op == OP_DATA);
  assign bus.lcd_clearreq = 1'b0;
  assign bus.lcd_homereq  = 1'b0;
  assign bus.lcd_cmdreq   = 1'b0;
  assign bus.lcd_din      = din_q;

endmodule

// File: tb/tb_lcd_line_writer.sv
// tb/tb_lcd_line_writer.sv - directed bench for lcd_line_writer with a 10-cycle clplcd model
module tb_lcd_line_writer;
  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  lcd_line_writer_if lif();

  lcd_line_writer #(
    .CHARS_PER_LINE(16),
    .LINE1_ADDR(7'h00),
    .LINE2_ADDR(7'h40),
    .TIMEOUT(100)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(lif)
  );

  int checks = 0;
  int errors = 0;

  // Controller model: done flag rises after 10 request cycles, sticky until lcd_init.
  int m_cnt = 0;
  bit rst_f = 0, addr_f = 0, data_f = 0;
  bit addr_en = 1, inject = 0;
  assign lif.lcd_reset_done = rst_f;
  assign lif.lcd_addr_done  = addr_f;
  assign lif.lcd_data_done  = data_f | inject;

  always @(negedge CLK) begin
    if (lif.lcd_init) begin
      m_cnt = 0; rst_f = 0; addr_f = 0; data_f = 0;
    end else if (lif.lcd_resetreq || lif.lcd_addrreq || lif.lcd_datareq) begin
      m_cnt++;
      if (m_cnt == 10) begin
        if (lif.lcd_resetreq) rst_f = 1;
        if (lif.lcd_addrreq && addr_en) addr_f = 1;
        if (lif.lcd_datareq) data_f = 1;
      end
    end
  end

  logic [7:0] din_q[$];
  int         op_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_buf[32];
  int init_cnt, done_cnt, busy_cyc, addr_hi, after_done, multi_req, unstable;
  bit prev_req = 0, prev_done = 0;
  logic [7:0] prev_din = 8'h00;

  always @(negedge CLK) begin
    bit any_req;
    any_req = lif.lcd_resetreq | lif.lcd_addrreq | lif.lcd_datareq;
    if (lif.lcd_init) init_cnt++;
    if (lif.done) done_cnt++;
    if (lif.busy) busy_cyc++;
    if (prev_done && lif.busy) after_done++;
    if (lif.lcd_addrreq) addr_hi++;
    if (32'(lif.lcd_resetreq) + 32'(lif.lcd_addrreq) + 32'(lif.lcd_datareq) > 1) multi_req++;
    if (any_req && prev_req && lif.lcd_din != prev_din) unstable++;
    if (any_req && !prev_req) begin
      din_q.push_back(lif.lcd_din);
      op_q.push_back(lif.lcd_resetreq ? 1 : (lif.lcd_addrreq ? 2 : 3));
    end
    prev_req  = any_req;
    prev_done = lif.done;
    prev_din  = lif.lcd_din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic clear_mon();
    din_q.delete(); op_q.delete();
    init_cnt = 0; done_cnt = 0; busy_cyc = 0; addr_hi = 0;
    after_done = 0; multi_req = 0; unstable = 0;
  endtask

  task automatic pulse_start();
    lif.start = 1; tick(); lif.start = 0;
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] d);
    lif.wr_en = 1; lif.wr_addr = a; lif.wr_data = d; tick(); lif.wr_en = 0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (lif.busy && n < budget) begin tick(); n++; end
    check(tag, lif.busy, 1'b0);
    tick();
  endtask

  task automatic compare_seq(input bit with_reset, input string tag);
    exp_q.delete();
    if (with_reset) exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_buf[i]);
    exp_q.push_back(8'h40);
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_buf[16+i]);
    check({tag, "_len"}, din_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < din_q.size()) check($sformatf("%s_din%0d", tag, i), din_q[i], exp_q[i]);
    check({tag, "_multi"}, multi_req, 0);
    check({tag, "_stable"}, unstable, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string l1, l2;
    int nrise;
    bit prev_dr;
    l1 = "HELLO WORLD     ";
    l2 = "LINE TWO        ";
    reset = 1; lif.start = 0; lif.wr_en = 0; lif.wr_addr = 0; lif.wr_data = 0;
    repeat (3) @(posedge CLK); #1;
    check("rst_busy", lif.busy, 0);
    check("rst_done", lif.done, 0);
    check("rst_error", lif.error, 0);
    check("rst_init", lif.lcd_init, 0);
    check("rst_reqs", {lif.lcd_resetreq, lif.lcd_addrreq, lif.lcd_datareq}, 3'b000);
    check("rst_tied", {lif.lcd_clearreq, lif.lcd_homereq, lif.lcd_cmdreq}, 3'b000);
    check("rst_din", lif.lcd_din, 8'h00);
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      write_char(5'(i), l1[i]);      exp_buf[i] = l1[i];
      write_char(5'(16 + i), l2[i]); exp_buf[16+i] = l2[i];
    end

    // First update: panel reset plus both lines.
    clear_mon();
    pulse_start();
    check("r1_accept_busy", lif.busy, 1);
    check("r1_accept_init", lif.lcd_init, 1);
    tick();
    check("r1_first_resetreq", lif.lcd_resetreq, 1);
    wait_idle(1000, "r1_idle");
    check("r1_inits", init_cnt, 35);
    check("r1_dones", done_cnt, 1);
    check("r1_busy_cycles", busy_cyc, 386);
    check("r1_busy_after_done", after_done, 0);
    check("r1_error", lif.error, 0);
    check("r1_op0", op_q[0], 1);
    check("r1_din2_H", din_q[2], 8'h48);
    check("r1_din3_E", din_q[3], 8'h45);
    check("r1_din18_addr2", din_q[18], 8'h40);
    check("r1_din19_L", din_q[19], 8'h4C);
    compare_seq(1, "r1");

    // Second update: no reset; stray data_done, write and start while busy all ignored.
    clear_mon();
    pulse_start();
    tick();
    inject = 1; repeat (3) tick(); inject = 0;
    repeat (5) tick();
    write_char(5'd5, 8'h41);
    repeat (40) tick();
    pulse_start();
    wait_idle(1000, "r2_idle");
    check("r2_op0_addr", op_q[0], 2);
    check("r2_din0", din_q[0], 8'h00);
    check("r2_pos5_old", din_q[6], 8'h20);
    check("r2_inits", init_cnt, 34);
    check("r2_dones", done_cnt, 1);
    check("r2_busy_cycles", busy_cyc, 375);
    compare_seq(0, "r2");
    repeat (3) tick();
    check("r2_stays_idle", lif.busy, 0);

    // Timeout on an address request that is never answered.
    addr_en = 0;
    clear_mon();
    pulse_start();
    wait_idle(400, "r3_idle");
    check("r3_addr_cycles", addr_hi, 100);
    check("r3_error", lif.error, 1);
    check("r3_dones", done_cnt, 0);
    check("r3_busy_cycles", busy_cyc, 101);
    addr_en = 1;

    // Recovery: re-reset, error cleared; a write alongside start lands first.
    clear_mon();
    lif.wr_en = 1; lif.wr_addr = 5'd16; lif.wr_data = 8'h51; lif.start = 1;
    tick();
    lif.wr_en = 0; lif.start = 0;
    exp_buf[16] = 8'h51;
    check("r4_error_cleared", lif.error, 0);
    check("r4_busy", lif.busy, 1);
    wait_idle(1000, "r4_idle");
    check("r4_op0_reset", op_q[0], 1);
    check("r4_inits", init_cnt, 35);
    check("r4_dones", done_cnt, 1);
    check("r4_din19_Q", din_q[19], 8'h51);
    compare_seq(1, "r4");

    // Reset during the 7th data character's request.
    clear_mon();
    pulse_start();
    nrise = 0; prev_dr = 0;
    for (int i = 0; i < 1000 && nrise < 7; i++) begin
      tick();
      if (lif.lcd_datareq && !prev_dr) nrise++;
      prev_dr = lif.lcd_datareq;
    end
    check("r5_found_7th", nrise, 7);
    repeat (2) tick();
    check("r5_in_req", lif.lcd_datareq, 1);
    reset = 1;
    tick();
    check("r5_reqs_dropped", {lif.lcd_resetreq, lif.lcd_addrreq, lif.lcd_datareq}, 3'b000);
    check("r5_busy", lif.busy, 0);
    reset = 0;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;

    clear_mon();
    pulse_start();
    wait_idle(1000, "r6_idle");
    check("r6_op0_reset", op_q[0], 1);
    check("r6_inits", init_cnt, 35);
    check("r6_dones", done_cnt, 1);
    compare_seq(1, "r6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_line_writer.md
Name: lcd_line_writer

Overview:
- Upstream sequencer for the parallel-interface character LCD controller (clplcd).
- Holds a 2x16 character message buffer that a host loads.
- On a start pulse it drives the controller's per-operation request/done handshake: a one-time panel reset, then a DDRAM address plus 16 characters per line.
- Gives the host a single start/busy/done/error interface instead of hand-sequencing LCD operations.

Parameters:
- CHARS_PER_LINE, 16: characters written per line; the buffer is 2*CHARS_PER_LINE bytes.
- LINE1_ADDR, 7'h00: DDRAM address of line 1.
- LINE2_ADDR, 7'h40: DDRAM address of line 2.
- TIMEOUT, 4194304: cycles to wait for a done flag before aborting (counter is 23 bits).

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a full-display update; sampled only in IDLE.
- wr_en  in  1  message buffer write strobe.
- wr_addr  in  5  buffer index: 0-15 is line 1, 16-31 is line 2.
- wr_data  in  8  ASCII character.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an update completes.
- error  out  1  sticky timeout flag.
- lcd_init  out  1  controller init pulse; clears the controller's state, counter and done flags.
- lcd_resetreq  out  1  panel reset request.
- lcd_addrreq  out  1  DDRAM address request.
- lcd_datareq  out  1  character write request.
- lcd_clearreq, lcd_homereq, lcd_cmdreq  out  1 each  tied to 0.
- lcd_din  out  8  data/address byte to the controller.
- lcd_reset_done, lcd_addr_done, lcd_data_done  in  1 each  controller done flags.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; panel_ready=0; line=0; char=0; timeout counter 0.
  - All 32 buffer bytes set to 8'h20 (space).
- Buffer writes:
  - When wr_en=1 and busy=0, buf[wr_addr] is written at the clock edge.
  - Writes while busy=1 are ignored.
- States: IDLE, ISSUE, REQ, FINISH.
- IDLE:
  - When start=1, go to ISSUE. Clear error, line and char.
  - op=RESET if panel_ready=0, otherwise op=ADDR.
  - start while busy is ignored.
- ISSUE (exactly one cycle):
  - lcd_init=1 and all requests 0.
  - lcd_din is loaded:
    - op ADDR: {1'b0, line ? LINE2_ADDR : LINE1_ADDR}.
    - op DATA: buf[line*CHARS_PER_LINE + char].
    - op RESET: 8'h00.
  - Timeout counter cleared. Next state REQ.
- REQ:
  - Exactly one request, the one matching op, is high. lcd_init=0.
  - lcd_din is held stable.
  - The counter increments each cycle.
- When REQ samples the done flag matching op (1), the request drops at that edge and the sequence advances:
  - RESET: panel_ready=1; op=ADDR; go to ISSUE.
  - ADDR: op=DATA; char=0; go to ISSUE.
  - DATA with char<CHARS_PER_LINE-1: char++; go to ISSUE.
  - DATA with char=CHARS_PER_LINE-1 and line=0: line=1; op=ADDR; go to ISSUE.
  - DATA with char=CHARS_PER_LINE-1 and line=1: go to FINISH.
- Done flags for other ops are ignored in REQ.
- FINISH: done=1 for one cycle, then IDLE.
- Timeout:
  - If the counter reaches TIMEOUT-1 in REQ without the matching done flag, the request drops and error=1.
  - panel_ready is cleared, so the next start re-resets the panel. Next state IDLE; no done pulse.
- Latency:
  - start accepted at edge N: busy=1 and lcd_init=1 in cycle N+1; request high from N+2.
  - done flag seen at edge M: next lcd_init in cycle M+1.
- Operation count per start:
  - First start after reset or after an error: 35 init pulses (1 reset + 2 addr + 32 data).
  - Every later start: 34 init pulses.
- Reset mid-operation:
  - All requests drop by the next cycle; state IDLE; panel_ready=0.
  - Buffer restored to spaces. The controller's stale state is harmless because every op begins with lcd_init.
- start and reset in the same cycle: reset wins.
- wr_en and start in the same cycle in IDLE: the write takes effect before the first ISSUE load.

Test Plan:
- Load "HELLO WORLD     " and "LINE TWO        " with a controller model that raises done 10 cycles after the request -> the lcd_din sequence is:
  - 00 (reset)
  - 00 (line 1 address), then 48 45 4C 4C 4F ...
  - 40 (line 2 address), then 4C 49 4E 45 ...
  - 35 lcd_init pulses, one done pulse, busy low the cycle after done.
- Second start with an unchanged buffer -> no lcd_resetreq; 34 lcd_init pulses; first lcd_din=00 on lcd_addrreq.
- TIMEOUT=100 and the model never answers lcd_addr_done -> lcd_addrreq high for exactly 100 cycles, then error=1, busy=0, no done. The next start issues lcd_resetreq first and clears error.
- wr_en to addr 5 with data 8'h41 while busy -> buffer unchanged; the next update still shows the old character at position 5.
- Assert reset 3 cycles into REQ of the 7th data character -> all requests 0 next cycle, busy=0. The next start issues lcd_resetreq and then sends 32 spaces (8'h20).
- Pulse start during REQ, and assert lcd_data_done while in an ADDR REQ -> both ignored; the sequence and done timing are unchanged.
